// File: rtl/bit_adder.sv
// Single-bit full adder cell for the ALU arithmetic datapath.
// Sum and carry-out are flopped by default, or passed straight through for combinational ripple chains.
module bit_adder #(
  parameter int OUTPUT_REG = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_o,
  output logic o_c
);

  logic sum_d;
  logic carry_d;

  assign sum_d   = i_a ^ i_b ^ i_c;
  assign carry_d = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

  generate
    if (OUTPUT_REG != 0) begin : g_reg
      logic sum_q;
      logic carry_q;

      always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
          sum_q   <= 1'b0;
          carry_q <= 1'b0;
        end else begin
          sum_q   <= sum_d;
          carry_q <= carry_d;
        end
      end

      assign o_o = sum_q;
      assign o_c = carry_q;
    end else begin : g_bypass
      // Clock and reset have no function in bypass mode; fold them into a sink.
      logic unused_clk_rst;
      assign unused_clk_rst = i_clk ^ i_reset;

      assign o_o = sum_d;
      assign o_c = carry_d;
    end
  endgenerate

endmodule

// File: tb/tb_bit_adder.sv
// Randomized self-checking bench for bit_adder, covering both registered and bypass builds.
module tb_bit_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b1;
  logic b = 1'b1;
  logic c = 1'b1;
  logic o_r, c_r, o_b, c_b;

  int n_checks = 0;
  int n_pass = 0;

  logic [1:0] exp_q[$];
  logic [1:0] prev;

  always #5 clk = ~clk;

  bit_adder #(.OUTPUT_REG(1)) dut_reg (
    .i_clk(clk), .i_reset(rst_n), .i_a(a), .i_b(b), .i_c(c), .o_o(o_r), .o_c(c_r)
  );

  bit_adder #(.OUTPUT_REG(0)) dut_byp (
    .i_clk(clk), .i_reset(rst_n), .i_a(a), .i_b(b), .i_c(c), .o_o(o_b), .o_c(c_b)
  );

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got {c,o}=%b expected %b", tag, got, exp);
  endtask

  // Reference: the pair {carry, sum} is just the arithmetic count of set input bits.
  function automatic logic [1:0] ref_add(input logic x, input logic y, input logic z);
    return {1'b0, x} + {1'b0, y} + {1'b0, z};
  endfunction

  task automatic drive(input logic [2:0] v);
    {a, b, c} = v;
  endtask

  initial begin
    int v;
    logic [1:0] e;

    // Reset held with inputs at 111 and the clock running.
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold", {c_r, o_r}, 2'b00);
    check("byp_in_rst", {c_b, o_b}, ref_add(a, b, c));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_after_release", {c_r, o_r}, 2'b11);

    // Async assertion between edges.
    #2 rst_n = 1'b0;
    #1 check("async_assert", {c_r, o_r}, 2'b00);
    @(posedge clk); #1;
    check("stay_in_reset", {c_r, o_r}, 2'b00);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("release_again", {c_r, o_r}, 2'b11);

    // Exhaustive truth table on both builds.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(i[2:0]);
      e = ref_add(a, b, c);
      #1 check("byp_tt", {c_b, o_b}, e);
      @(posedge clk); #1;
      check("reg_tt", {c_r, o_r}, e);
      prev = e;
    end

    // Hold: mid-cycle glitch to 111 must not reach the registered outputs.
    drive(3'b100);
    #1 check("hold_a", {c_r, o_r}, prev);
    #1 drive(3'b111);
    #1 check("hold_b", {c_r, o_r}, prev);
    #1 drive(3'b100);
    @(posedge clk); #1;
    check("hold_edge", {c_r, o_r}, 2'b01);

    // Back-to-back alternation 111 / 000.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive((i % 2 == 0) ? 3'b111 : 3'b000);
      @(posedge clk); #1;
      check("b2b", {c_r, o_r}, (i % 2 == 0) ? 2'b11 : 2'b00);
    end

    // Random traffic with mid-cycle glitches and one async reset in the middle.
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      v = $urandom_range(0, 7);
      drive(v[2:0]);
      exp_q.push_back(ref_add(a, b, c));
      #1 check("byp_rand", {c_b, o_b}, exp_q[$]);
      #1 drive(3'($urandom_range(0, 7)));
      #1 drive(v[2:0]);
      @(posedge clk); #1;
      check("reg_rand", {c_r, o_r}, exp_q.pop_front());
      if (i == 30) begin
        #2 rst_n = 1'b0;
        #1 check("rand_async_rst", {c_r, o_r}, 2'b00);
        exp_q.delete();
        @(posedge clk); #1;
        check("rand_in_rst", {c_r, o_r}, 2'b00);
        @(negedge clk); rst_n = 1'b1;
      end
    end

    // Bypass ignores reset; registered build stays cleared.
    rst_n = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      drive(i[2:0]);
      #1 check("byp_rst_sweep", {c_b, o_b}, ref_add(a, b, c));
      check("reg_rst_sweep", {c_r, o_r}, 2'b00);
      #2;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
